// File: rtl/cr16_ctrl_fsm_ws.sv
// Multi-cycle control sequencer for the 16-bit CR16-style datapath.
// Configurable memory wait (fixed count or mem_ready handshake), halt at instruction boundary, sticky fault.
module cr16_ctrl_fsm_ws #(
    parameter int MEM_LAT          = 2,
    parameter int MEM_READY_MODE   = 0,
    parameter int MAX_WAIT         = 15,
    parameter int FAULT_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opCode1,
    input  logic [3:0] opCode2,
    input  logic [3:0] conditionCode,
    input  logic [3:0] shiftAmtIn,
    input  logic [7:0] PSR,
    input  logic       mem_ready,
    input  logic       halt,
    output logic       storeReg,
    output logic       zeroExtend,
    output logic       SrcB,
    output logic       JmpEN,
    output logic       BranchEN,
    output logic       JALEN,
    output logic       PCEN,
    output logic       resultEN,
    output logic       immediateRegEN,
    output logic       updateAddress,
    output logic       wren_a,
    output logic       wren_b,
    output logic       nextInstruction,
    output logic       writeData,
    output logic       PSREN,
    output logic       regWriteEN,
    output logic       PCinstruction,
    output logic       regDest,
    output logic [3:0] shifterControl,
    output logic [3:0] ALUcontrol,
    output logic [1:0] result,
    output logic [3:0] shiftAmtOut,
    output logic       idle,
    output logic       instr_done,
    output logic       fault
);

    // state     | meaning
    // IDLE      | halted, waiting for halt = 0
    // FETCH     | PC drives memory, PC increments
    // FWAIT     | instruction memory wait
    // DECODE    | immediate captured, dispatch on opCode1
    // MEMADR    | memory/jump group, dispatch on opCode2
    // LB_RD     | load address presented
    // LWAIT     | data memory wait
    // LB_WR     | load data written to register file
    // SB_WR     | store write strobe
    // RTYPE_EX  | register-register ALU op
    // RTYPE_WR  | register-register writeback
    // ITYPE_EX  | immediate ALU op
    // ITYPE_WR  | immediate writeback
    // SHIFT_EX  | shifter op
    // SHIFT_WR  | shifter writeback
    // BCOND_EX  | conditional branch
    // JAL_EX    | jump-and-link, link value computed
    // JAL_WR    | link register written
    // JCOND_EX  | conditional jump
    // FAULT     | illegal opcode or memory timeout, reset only
    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_MEMADR,
        S_LB_RD, S_LWAIT, S_LB_WR, S_SB_WR,
        S_RTYPE_EX, S_RTYPE_WR, S_ITYPE_EX, S_ITYPE_WR,
        S_SHIFT_EX, S_SHIFT_WR, S_BCOND_EX,
        S_JAL_EX, S_JAL_WR, S_JCOND_EX, S_FAULT
    } state_t;

    localparam bit          HAS_WAIT = (MEM_READY_MODE != 0) || (MEM_LAT > 1);
    localparam logic [15:0] FIX_LAST = 16'(MEM_LAT - 2);
    localparam logic [15:0] TO_LAST  = 16'(MAX_WAIT - 1);
    localparam state_t      ILL_NEXT = (FAULT_ON_ILLEGAL != 0) ? S_FAULT : S_FETCH;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        wait_exit;
    logic        wait_tmo;
    logic        pass;
    logic        unused_psr;

    assign unused_psr  = ^PSR[7:5];
    assign shiftAmtOut = shiftAmtIn;

    always_comb begin
        wait_exit = 1'b0;
        wait_tmo  = 1'b0;
        if (MEM_READY_MODE != 0) begin
            wait_exit = mem_ready;
            wait_tmo  = !mem_ready && (wait_cnt == TO_LAST);
        end else begin
            wait_exit = (wait_cnt == FIX_LAST);
        end
    end

    always_comb begin
        pass = 1'b0;
        case (conditionCode)
            4'h0: pass = PSR[4];
            4'h1: pass = !PSR[4];
            4'h2: pass = PSR[3];
            4'h3: pass = !PSR[3];
            4'h4: pass = PSR[0];
            4'h5: pass = !PSR[0];
            4'h6: pass = PSR[1];
            4'h7: pass = !PSR[1];
            4'h8: pass = PSR[2];
            4'h9: pass = !PSR[2];
            4'hA: pass = !PSR[4] && !PSR[0];
            4'hB: pass = PSR[4] || PSR[0];
            4'hC: pass = !PSR[1] && !PSR[4];
            4'hD: pass = PSR[4] || PSR[1];
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (!halt) state <= S_FETCH;
                S_FETCH: begin
                    wait_cnt <= '0;
                    state    <= HAS_WAIT ? S_FWAIT : S_DECODE;
                end
                S_FWAIT: begin
                    if (wait_tmo)       state <= S_FAULT;
                    else if (wait_exit) state <= S_DECODE;
                    else                wait_cnt <= wait_cnt + 16'd1;
                end
                S_DECODE: begin
                    case (opCode1)
                        4'h0:                                    state <= S_RTYPE_EX;
                        4'h4:                                    state <= S_MEMADR;
                        4'h8, 4'hF:                              state <= S_SHIFT_EX;
                        4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: state <= S_ITYPE_EX;
                        4'hC:                                    state <= S_BCOND_EX;
                        default:                                 state <= ILL_NEXT;
                    endcase
                end
                S_MEMADR: begin
                    case (opCode2)
                        4'h0:    state <= S_LB_RD;
                        4'h4:    state <= S_SB_WR;
                        4'h8:    state <= S_JAL_EX;
                        4'hC:    state <= S_JCOND_EX;
                        default: state <= ILL_NEXT;
                    endcase
                end
                S_LB_RD: begin
                    wait_cnt <= '0;
                    state    <= HAS_WAIT ? S_LWAIT : S_LB_WR;
                end
                S_LWAIT: begin
                    if (wait_tmo)       state <= S_FAULT;
                    else if (wait_exit) state <= S_LB_WR;
                    else                wait_cnt <= wait_cnt + 16'd1;
                end
                S_RTYPE_EX: state <= S_RTYPE_WR;
                S_ITYPE_EX: state <= S_ITYPE_WR;
                S_SHIFT_EX: state <= S_SHIFT_WR;
                S_JAL_EX:   state <= S_JAL_WR;
                // instruction boundary: the only place halt is honoured
                S_LB_WR, S_SB_WR, S_RTYPE_WR, S_ITYPE_WR, S_SHIFT_WR,
                S_BCOND_EX, S_JAL_WR, S_JCOND_EX:
                    state <= halt ? S_IDLE : S_FETCH;
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        storeReg        = 1'b0;
        zeroExtend      = 1'b1;
        SrcB            = 1'b1;
        JmpEN           = 1'b0;
        BranchEN        = 1'b0;
        JALEN           = 1'b0;
        PCEN            = 1'b0;
        resultEN        = 1'b0;
        immediateRegEN  = 1'b0;
        updateAddress   = 1'b1;
        wren_a          = 1'b0;
        wren_b          = 1'b0;
        nextInstruction = 1'b0;
        writeData       = 1'b1;
        PSREN           = 1'b0;
        regWriteEN      = 1'b0;
        PCinstruction   = 1'b0;
        regDest         = 1'b1;
        shifterControl  = 4'h0;
        ALUcontrol      = 4'h5;
        result          = 2'h1;
        idle            = 1'b0;
        instr_done      = 1'b0;
        fault           = 1'b0;
        case (state)
            S_IDLE: idle = 1'b1;
            S_FETCH: begin
                nextInstruction = 1'b1;
                PCinstruction   = 1'b1;
                PCEN            = 1'b1;
            end
            S_FWAIT: nextInstruction = 1'b1;
            S_DECODE: begin
                SrcB           = 1'b0;
                immediateRegEN = 1'b1;
                if (opCode2[3]) zeroExtend = (opCode1 inside {4'h1, 4'h2, 4'h3, 4'hD});
            end
            S_LB_RD, S_LWAIT: updateAddress = 1'b0;
            S_LB_WR: begin
                writeData  = 1'b0;
                regWriteEN = 1'b1;
                instr_done = 1'b1;
            end
            S_SB_WR: begin
                storeReg      = 1'b1;
                updateAddress = 1'b0;
                wren_a        = 1'b1;
                instr_done    = 1'b1;
            end
            S_RTYPE_EX: begin
                ALUcontrol = opCode2;
                PSREN      = (opCode2 != 4'h0);
                resultEN   = (opCode2 != 4'h0);
            end
            S_RTYPE_WR: begin
                regWriteEN = !(opCode2 inside {4'h0, 4'hB});
                instr_done = 1'b1;
            end
            S_ITYPE_EX: begin
                ALUcontrol = opCode1;
                SrcB       = 1'b0;
                PSREN      = 1'b1;
                resultEN   = 1'b1;
            end
            S_ITYPE_WR: begin
                regWriteEN = (opCode1 != 4'hB);
                instr_done = 1'b1;
            end
            S_SHIFT_EX: begin
                shifterControl = (opCode1 == 4'hF) ? opCode1 : opCode2;
                SrcB           = (opCode1 != 4'hF) && (opCode2 == 4'h4);
                result         = 2'h0;
                resultEN       = 1'b1;
            end
            S_SHIFT_WR: begin
                regWriteEN = 1'b1;
                instr_done = 1'b1;
            end
            S_BCOND_EX: begin
                BranchEN      = pass;
                PCinstruction = 1'b1;
                PCEN          = 1'b1;
                SrcB          = 1'b0;
                zeroExtend    = 1'b0;
                instr_done    = 1'b1;
            end
            S_JAL_EX: begin
                JALEN         = 1'b1;
                PCinstruction = 1'b1;
                PCEN          = 1'b1;
                resultEN      = 1'b1;
                result        = 2'h3;
            end
            S_JAL_WR: begin
                regWriteEN = 1'b1;
                regDest    = 1'b0;
                instr_done = 1'b1;
            end
            S_JCOND_EX: begin
                JmpEN         = pass;
                PCinstruction = 1'b1;
                PCEN          = 1'b1;
                instr_done    = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cr16_ctrl_fsm_ws.sv
// Bench for cr16_ctrl_fsm_ws: three configurations (fixed latency 2, handshake with timeout 4, latency 1 without fault on illegal).
// Expected per-cycle outputs are pushed to a scoreboard queue and popped at the falling edge.
module tb_cr16_ctrl_fsm_ws;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [3:0] opCode1, opCode2, conditionCode, shiftAmtIn;
    logic [7:0] PSR;
    logic       mem_ready, halt;

    typedef struct packed {
        logic storeReg, zeroExtend, SrcB, JmpEN, BranchEN, JALEN, PCEN, resultEN, immediateRegEN;
        logic updateAddress, wren_a, wren_b, nextInstruction, writeData, PSREN, regWriteEN, PCinstruction, regDest;
        logic [3:0] shc, alu;
        logic [1:0] res;
        logic idle, done, fault;
        logic [3:0] sa;
    } outs_t;

    outs_t outs [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic storeReg, zeroExtend, SrcB, JmpEN, BranchEN, JALEN, PCEN, resultEN, immediateRegEN;
        logic updateAddress, wren_a, wren_b, nextInstruction, writeData, PSREN, regWriteEN, PCinstruction, regDest;
        logic [3:0] shifterControl, ALUcontrol, shiftAmtOut;
        logic [1:0] result;
        logic idle, instr_done, fault;

        cr16_ctrl_fsm_ws #(
            .MEM_LAT(g == 2 ? 1 : 2), .MEM_READY_MODE(g == 1 ? 1 : 0),
            .MAX_WAIT(g == 1 ? 4 : 15), .FAULT_ON_ILLEGAL(g == 2 ? 0 : 1)
        ) u_dut (
            .clk(clk), .reset(rst[g]), .opCode1(opCode1), .opCode2(opCode2),
            .conditionCode(conditionCode), .shiftAmtIn(shiftAmtIn), .PSR(PSR),
            .mem_ready(mem_ready), .halt(halt),
            .storeReg(storeReg), .zeroExtend(zeroExtend), .SrcB(SrcB), .JmpEN(JmpEN),
            .BranchEN(BranchEN), .JALEN(JALEN), .PCEN(PCEN), .resultEN(resultEN),
            .immediateRegEN(immediateRegEN), .updateAddress(updateAddress), .wren_a(wren_a),
            .wren_b(wren_b), .nextInstruction(nextInstruction), .writeData(writeData),
            .PSREN(PSREN), .regWriteEN(regWriteEN), .PCinstruction(PCinstruction),
            .regDest(regDest), .shifterControl(shifterControl), .ALUcontrol(ALUcontrol),
            .result(result), .shiftAmtOut(shiftAmtOut), .idle(idle),
            .instr_done(instr_done), .fault(fault)
        );

        assign outs[g] = {storeReg, zeroExtend, SrcB, JmpEN, BranchEN, JALEN, PCEN, resultEN, immediateRegEN,
                          updateAddress, wren_a, wren_b, nextInstruction, writeData, PSREN, regWriteEN,
                          PCinstruction, regDest, shifterControl, ALUcontrol, result, idle, instr_done,
                          fault, shiftAmtOut};
    end

    typedef enum int {
        B_IDLE, B_FETCH, B_FWAIT, B_DECODE, B_MEMADR, B_LBRD, B_LWAIT, B_LBWR, B_SBWR,
        B_REX, B_RWR, B_IEX, B_IWR, B_SEX, B_SWR, B_BCOND, B_JALEX, B_JALWR, B_JCOND, B_FAULT
    } bst_t;
    typedef enum int {C_R, C_I, C_S, C_LB, C_SB, C_JAL, C_JC, C_B} cls_t;

    typedef struct packed {
        logic [3:0] op1, op2, cc;
        logic [7:0] psr;
        cls_t       cls;
        logic       pass;
    } vec_t;

    typedef struct packed {
        bst_t  st;
        outs_t exp;
    } sb_t;

    sb_t  sbq [$];
    vec_t tbl [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   sel     = 0;
    logic cur_pass;

    function automatic outs_t exp_out(bst_t st, logic [3:0] o1, logic [3:0] o2, logic [3:0] sa, logic p);
        outs_t e;
        e = '0;
        e.zeroExtend = 1'b1; e.SrcB = 1'b1; e.updateAddress = 1'b1; e.writeData = 1'b1; e.regDest = 1'b1;
        e.alu = 4'h5; e.res = 2'h1; e.sa = sa;
        case (st)
            B_IDLE:   e.idle = 1'b1;
            B_FETCH:  begin e.nextInstruction = 1'b1; e.PCinstruction = 1'b1; e.PCEN = 1'b1; end
            B_FWAIT:  e.nextInstruction = 1'b1;
            B_DECODE: begin
                e.SrcB = 1'b0; e.immediateRegEN = 1'b1;
                e.zeroExtend = o2[3] ? (o1 == 4'h1 || o1 == 4'h2 || o1 == 4'h3 || o1 == 4'hD) : 1'b1;
            end
            B_LBRD, B_LWAIT: e.updateAddress = 1'b0;
            B_LBWR:   begin e.writeData = 1'b0; e.regWriteEN = 1'b1; e.done = 1'b1; end
            B_SBWR:   begin e.storeReg = 1'b1; e.updateAddress = 1'b0; e.wren_a = 1'b1; e.done = 1'b1; end
            B_REX:    begin e.alu = o2; e.PSREN = (o2 != 0); e.resultEN = (o2 != 0); end
            B_RWR:    begin e.regWriteEN = (o2 != 4'h0 && o2 != 4'hB); e.done = 1'b1; end
            B_IEX:    begin e.alu = o1; e.SrcB = 1'b0; e.PSREN = 1'b1; e.resultEN = 1'b1; end
            B_IWR:    begin e.regWriteEN = (o1 != 4'hB); e.done = 1'b1; end
            B_SEX:    begin
                e.shc = (o1 == 4'hF) ? 4'hF : o2;
                e.SrcB = (o1 != 4'hF && o2 == 4'h4);
                e.res = 2'h0; e.resultEN = 1'b1;
            end
            B_SWR:    begin e.regWriteEN = 1'b1; e.done = 1'b1; end
            B_BCOND:  begin
                e.BranchEN = p; e.PCinstruction = 1'b1; e.PCEN = 1'b1;
                e.SrcB = 1'b0; e.zeroExtend = 1'b0; e.done = 1'b1;
            end
            B_JALEX:  begin e.JALEN = 1'b1; e.PCinstruction = 1'b1; e.PCEN = 1'b1; e.resultEN = 1'b1; e.res = 2'h3; end
            B_JALWR:  begin e.regWriteEN = 1'b1; e.regDest = 1'b0; e.done = 1'b1; end
            B_JCOND:  begin e.JmpEN = p; e.PCinstruction = 1'b1; e.PCEN = 1'b1; e.done = 1'b1; end
            B_FAULT:  e.fault = 1'b1;
            default:  ;
        endcase
        return e;
    endfunction

    task automatic step(bst_t st);
        sb_t   e;
        outs_t got;
        e.st  = st;
        e.exp = exp_out(st, opCode1, opCode2, shiftAmtIn, cur_pass);
        sbq.push_back(e);
        @(negedge clk);
        e   = sbq.pop_front();
        got = outs[sel];
        n_tests++;
        if (got !== e.exp) begin
            n_fail++;
            $display("FAIL dut%0d state %s: got %h required %h", sel, e.st.name(), got, e.exp);
        end
    endtask

    task automatic add(logic [3:0] o1, logic [3:0] o2, logic [3:0] cc, logic [7:0] psr, cls_t c, logic p);
        vec_t v;
        v.op1 = o1; v.op2 = o2; v.cc = cc; v.psr = psr; v.cls = c; v.pass = p;
        tbl.push_back(v);
    endtask

    task automatic run(vec_t v, bit fast);
        opCode1 = v.op1; opCode2 = v.op2; conditionCode = v.cc; PSR = v.psr; cur_pass = v.pass;
        shiftAmtIn = 4'($urandom_range(0, 15));
        step(B_FETCH);
        if (!fast) step(B_FWAIT);
        step(B_DECODE);
        case (v.cls)
            C_R:   begin step(B_REX); step(B_RWR); end
            C_I:   begin step(B_IEX); step(B_IWR); end
            C_S:   begin step(B_SEX); step(B_SWR); end
            C_LB:  begin step(B_MEMADR); step(B_LBRD); if (!fast) step(B_LWAIT); step(B_LBWR); end
            C_SB:  begin step(B_MEMADR); step(B_SBWR); end
            C_JAL: begin step(B_MEMADR); step(B_JALEX); step(B_JALWR); end
            C_JC:  begin step(B_MEMADR); step(B_JCOND); end
            default: step(B_BCOND);
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        add(4'h5, 4'h0, 4'h0, 8'h00, C_I, 1'b0);
        add(4'h0, 4'h5, 4'h0, 8'h00, C_R, 1'b0);
        add(4'h0, 4'h0, 4'h0, 8'h00, C_R, 1'b0);
        add(4'h0, 4'hB, 4'h0, 8'h00, C_R, 1'b0);
        add(4'hB, 4'h0, 4'h0, 8'h00, C_I, 1'b0);
        add(4'h1, 4'h8, 4'h0, 8'h00, C_I, 1'b0);
        add(4'h9, 4'h8, 4'h0, 8'h00, C_I, 1'b0);
        add(4'h8, 4'h4, 4'h0, 8'h00, C_S, 1'b0);
        add(4'hF, 4'h2, 4'h0, 8'h00, C_S, 1'b0);
        add(4'h8, 4'h0, 4'h0, 8'h00, C_S, 1'b0);
        add(4'h4, 4'h0, 4'h0, 8'h00, C_LB, 1'b0);
        add(4'h4, 4'h4, 4'h0, 8'h00, C_SB, 1'b0);
        add(4'h4, 4'h8, 4'h0, 8'h00, C_JAL, 1'b0);
        add(4'h4, 4'hC, 4'hE, 8'h00, C_JC, 1'b1);
        add(4'h4, 4'hC, 4'hF, 8'hFF, C_JC, 1'b0);
        add(4'hC, 4'h0, 4'hD, 8'h02, C_B, 1'b1);
        add(4'hC, 4'h0, 4'hC, 8'h02, C_B, 1'b0);
        add(4'hC, 4'h0, 4'h0, 8'h10, C_B, 1'b1);
        add(4'hC, 4'h0, 4'hA, 8'h00, C_B, 1'b1);
        add(4'hC, 4'h0, 4'hB, 8'h00, C_B, 1'b0);
        add(4'hC, 4'h0, 4'h5, 8'h01, C_B, 1'b0);
        add(4'hC, 4'h0, 4'h8, 8'h04, C_B, 1'b1);
        add(4'hC, 4'h0, 4'h3, 8'h08, C_B, 1'b0);
        add(4'hC, 4'h0, 4'h7, 8'hE0, C_B, 1'b1);

        rst = 3'b111; halt = 1'b0; mem_ready = 1'b0; cur_pass = 1'b0; sel = 0;
        opCode1 = 4'h0; opCode2 = 4'h0; conditionCode = 4'h0; shiftAmtIn = 4'h0; PSR = 8'h00;

        // reset state, then IDLE held by halt
        step(B_IDLE);
        step(B_IDLE);
        rst[0] = 1'b0; halt = 1'b1;
        step(B_IDLE);
        step(B_IDLE);
        halt = 1'b0;

        foreach (tbl[i]) run(tbl[i], 1'b0);

        // halt raised during RTYPE_EX
        opCode1 = 4'h0; opCode2 = 4'h3; cur_pass = 1'b0;
        step(B_FETCH); step(B_FWAIT); step(B_DECODE); step(B_REX);
        halt = 1'b1;
        step(B_RWR); step(B_IDLE); step(B_IDLE); step(B_IDLE);
        halt = 1'b0;
        step(B_FETCH); step(B_FWAIT);

        // reset mid-wait abandons the instruction
        rst[0] = 1'b1;
        step(B_IDLE);
        rst[0] = 1'b0; opCode1 = 4'hA; opCode2 = 4'h0;
        step(B_FETCH); step(B_FWAIT); step(B_DECODE); step(B_FAULT);
        mem_ready = 1'b1; halt = 1'b1;
        step(B_FAULT); step(B_FAULT);
        mem_ready = 1'b0; halt = 1'b0; rst[0] = 1'b1;
        step(B_IDLE);
        rst[0] = 1'b0; opCode1 = 4'h4; opCode2 = 4'h2;
        step(B_FETCH); step(B_FWAIT); step(B_DECODE); step(B_MEMADR); step(B_FAULT);
        rst[0] = 1'b1;
        step(B_IDLE);

        // handshake configuration
        sel = 1; rst[1] = 1'b0; opCode1 = 4'h4; opCode2 = 4'h0;
        step(B_FETCH); step(B_FWAIT);
        mem_ready = 1'b1;
        step(B_DECODE); step(B_MEMADR);
        mem_ready = 1'b0;
        step(B_LBRD); step(B_LWAIT); step(B_LWAIT); step(B_LWAIT);
        mem_ready = 1'b1;
        step(B_LBWR);
        mem_ready = 1'b0; opCode1 = 4'h5;
        step(B_FETCH); step(B_FWAIT); step(B_FWAIT); step(B_FWAIT); step(B_FWAIT);
        step(B_FAULT); step(B_FAULT);
        rst[1] = 1'b1;
        step(B_IDLE);

        // single-cycle memory, illegal opcode returns to FETCH
        sel = 2; rst[2] = 1'b0;
        run(tbl[0], 1'b1);
        run(tbl[10], 1'b1);
        run(tbl[15], 1'b1);
        opCode1 = 4'hA; opCode2 = 4'h0; cur_pass = 1'b0;
        step(B_FETCH); step(B_DECODE); step(B_FETCH);
        opCode1 = 4'h4; opCode2 = 4'h6;
        step(B_DECODE); step(B_MEMADR); step(B_FETCH);
        opCode1 = 4'h5; opCode2 = 4'h0;
        step(B_DECODE); step(B_IEX); step(B_IWR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
